// File: rtl/scope_cap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scope_cap_pkg
// Purpose  : Shared state encoding, edge-select constants and default widths
//            for the scope trigger/capture stage.
// Revision : 1.0 - initial release
// ============================================================================
package scope_cap_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_DEPTH_WIDTH = 10;
    localparam int DEF_DECIM_WIDTH = 16;

    localparam logic EDGE_RISING  = 1'b0;
    localparam logic EDGE_FALLING = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMED     = 3'd1,
        WAIT_TRIG = 3'd2,
        CAPTURE   = 3'd3,
        DONE      = 3'd4
    } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/sample_decimator.sv
`default_nettype none
// ============================================================================
// Module   : sample_decimator
// Purpose  : Keeps one of every (i_decim+1) valid samples; o_accept marks the
//            kept sample. i_clear restarts so the next valid sample is kept.
// Revision : 1.0 - initial release
// ============================================================================
module sample_decimator
    import scope_cap_pkg::*;
#(
    parameter int DECIM_WIDTH = DEF_DECIM_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic                   i_clear,
    input  logic [DECIM_WIDTH-1:0] i_decim,
    output logic                   o_accept
);

    localparam logic [DECIM_WIDTH-1:0] c_ONE = DECIM_WIDTH'(1);

    logic [DECIM_WIDTH-1:0] r_dcnt;

    assign o_accept = i_valid && (r_dcnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dcnt <= '0;
        end else if (i_clear) begin
            r_dcnt <= '0;
        end else if (o_accept) begin
            r_dcnt <= i_decim;
        end else if (i_valid) begin
            r_dcnt <= r_dcnt - c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_trig_capture.sv
`default_nettype none
// ============================================================================
// Module   : adc_trig_capture
// Purpose  : Decimates the ADC stream, waits for a level-crossing trigger once
//            armed, then writes capture_len samples into the FIFO write port.
//            Optional macro TRIG_AUTO_EN adds a timeout auto-trigger.
// Revision : 1.0 - initial release
// ============================================================================
module adc_trig_capture
    import scope_cap_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DEPTH_WIDTH = DEF_DEPTH_WIDTH,
`ifdef TRIG_AUTO_EN
    parameter int AUTO_CYCLES = 1000000,
`endif
    parameter int DECIM_WIDTH = DEF_DECIM_WIDTH
) (
    input  logic                   wr_clk,
    input  logic                   wr_rst,
    input  logic [DATA_WIDTH-1:0]  adc_data,
    input  logic                   adc_valid,
    input  logic                   arm,
    input  logic [DATA_WIDTH-1:0]  trig_level,
    input  logic                   trig_edge,
    input  logic [DECIM_WIDTH-1:0] decim,
    input  logic [DEPTH_WIDTH:0]   capture_len,
    output logic                   wr_en,
    output logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_full,
    output logic                   busy,
    output logic                   triggered,
    output logic                   done,
`ifdef TRIG_AUTO_EN
    output logic                   auto_trig,
`endif
    output logic                   overflow
);

    localparam logic [DEPTH_WIDTH:0] c_LEN_MAX = {1'b1, {DEPTH_WIDTH{1'b0}}};
    localparam logic [DEPTH_WIDTH:0] c_LEN_ONE = (DEPTH_WIDTH + 1)'(1);

    cap_state_t             r_state;
    cap_state_t             w_state_nxt;
    logic [DECIM_WIDTH-1:0] r_decim;
    logic [DATA_WIDTH-1:0]  r_level;
    logic                   r_edge;
    logic [DEPTH_WIDTH:0]   r_len;
    logic [DEPTH_WIDTH:0]   r_wcnt;
    logic [DATA_WIDTH-1:0]  r_prev;
    logic                   r_triggered;
    logic                   r_overflow;
    logic                   r_wr_en;
    logic [DATA_WIDTH-1:0]  r_wr_data;

    logic w_accept;
    logic w_arm_ok;
    logic w_rise;
    logic w_fall;
    logic w_hit;
    logic w_auto_fire;
    logic w_fire;
    logic w_write;
    logic w_drop;
    logic w_load_prev;

    sample_decimator #(
        .DECIM_WIDTH (DECIM_WIDTH)
    ) u_decim (
        .clk      (wr_clk),
        .rst      (wr_rst),
        .i_valid  (adc_valid),
        .i_clear  (w_arm_ok),
        .i_decim  (r_decim),
        .o_accept (w_accept)
    );

    assign w_arm_ok = arm && ((r_state == IDLE) || (r_state == DONE));
    assign w_rise   = (r_prev < r_level) && (adc_data >= r_level);
    assign w_fall   = (r_prev > r_level) && (adc_data <= r_level);

    always_comb begin
        w_hit = 1'b0;
        case (r_edge)
            EDGE_RISING:  w_hit = w_rise;
            EDGE_FALLING: w_hit = w_fall;
            default:      w_hit = 1'b0;
        endcase
    end

`ifdef TRIG_AUTO_EN
    localparam int                    c_AUTO_W   = $clog2(AUTO_CYCLES + 1);
    localparam logic [c_AUTO_W-1:0]   c_AUTO_MAX = c_AUTO_W'(AUTO_CYCLES);

    logic [c_AUTO_W-1:0] r_auto_cnt;
    logic                r_auto_trig;

    // Saturates so a slow/absent sample stream still fires on the next accept
    always_ff @(posedge wr_clk) begin
        if (wr_rst || (r_state != WAIT_TRIG)) begin
            r_auto_cnt <= '0;
        end else if (r_auto_cnt != c_AUTO_MAX) begin
            r_auto_cnt <= r_auto_cnt + c_AUTO_W'(1);
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst || w_arm_ok) begin
            r_auto_trig <= 1'b0;
        end else if (w_fire && !w_hit) begin
            r_auto_trig <= 1'b1;
        end
    end

    assign w_auto_fire = (r_auto_cnt == c_AUTO_MAX);
    assign auto_trig   = r_auto_trig;
`else
    assign w_auto_fire = 1'b0;
`endif

    // Next-state and per-cycle write/drop decisions
    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        w_write     = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (arm) w_state_nxt = ARMED;
            end
            ARMED: begin
                if (w_accept) w_state_nxt = WAIT_TRIG;
            end
            WAIT_TRIG: begin
                if (w_accept && (w_hit || w_auto_fire)) begin
                    w_fire = 1'b1;
                    if (r_len == '0) begin
                        w_state_nxt = DONE;
                    end else if (wr_full) begin
                        w_drop      = 1'b1;
                        w_state_nxt = CAPTURE;
                    end else begin
                        w_write     = 1'b1;
                        w_state_nxt = (r_len == c_LEN_ONE) ? DONE : CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (w_accept) begin
                    if (wr_full) begin
                        w_drop = 1'b1;
                    end else begin
                        w_write = 1'b1;
                        if ((r_wcnt + c_LEN_ONE) == r_len) w_state_nxt = DONE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_load_prev = w_accept && ((r_state == ARMED) || (r_state == WAIT_TRIG));

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_decim     <= '0;
            r_level     <= '0;
            r_edge      <= EDGE_RISING;
            r_len       <= '0;
            r_wcnt      <= '0;
            r_prev      <= '0;
            r_triggered <= 1'b0;
            r_overflow  <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
        end else begin
            r_wr_en <= w_write;
            if (w_write) begin
                r_wr_data <= adc_data;
                r_wcnt    <= r_wcnt + c_LEN_ONE;
            end
            if (w_load_prev)        r_prev      <= adc_data;
            if (w_fire && w_hit)    r_triggered <= 1'b1;
            if (w_drop)             r_overflow  <= 1'b1;
            if (w_arm_ok) begin
                r_decim     <= decim;
                r_level     <= trig_level;
                r_edge      <= trig_edge;
                r_len       <= (capture_len > c_LEN_MAX) ? c_LEN_MAX : capture_len;
                r_wcnt      <= '0;
                r_triggered <= 1'b0;
                r_overflow  <= 1'b0;
            end
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_data   = r_wr_data;
    assign busy      = (r_state == ARMED) || (r_state == WAIT_TRIG) || (r_state == CAPTURE);
    assign done      = (r_state == DONE);
    assign triggered = r_triggered;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_adc_trig_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_trig_capture
// Purpose  : Self-checking bench; sample-stream reference model vs. DUT writes
//            and status flags. Build with TRIG_AUTO_EN to cover auto-trigger.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_trig_capture;

    localparam int DEP  = 4;
    localparam int MAXC = 8192;
`ifdef TRIG_AUTO_EN
    localparam int AUTO = 50;
`endif

    logic        wr_clk      = 1'b0;
    logic        wr_rst      = 1'b1;
    logic [7:0]  adc_data    = '0;
    logic        adc_valid   = 1'b0;
    logic        arm         = 1'b0;
    logic [7:0]  trig_level  = '0;
    logic        trig_edge   = 1'b0;
    logic [15:0] decim       = '0;
    logic [DEP:0] capture_len = '0;
    logic        wr_full     = 1'b0;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        busy;
    logic        triggered;
    logic        done;
    logic        overflow;
`ifdef TRIG_AUTO_EN
    logic        auto_trig;
`endif

    adc_trig_capture #(
        .DATA_WIDTH  (8),
        .DEPTH_WIDTH (DEP),
`ifdef TRIG_AUTO_EN
        .AUTO_CYCLES (AUTO),
`endif
        .DECIM_WIDTH (16)
    ) dut (
        .wr_clk      (wr_clk),
        .wr_rst      (wr_rst),
        .adc_data    (adc_data),
        .adc_valid   (adc_valid),
        .arm         (arm),
        .trig_level  (trig_level),
        .trig_edge   (trig_edge),
        .decim       (decim),
        .capture_len (capture_len),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_full     (wr_full),
        .busy        (busy),
        .triggered   (triggered),
        .done        (done),
`ifdef TRIG_AUTO_EN
        .auto_trig   (auto_trig),
`endif
        .overflow    (overflow)
    );

    always #5 wr_clk = ~wr_clk;

    logic [7:0] s_data  [MAXC];
    bit         s_valid [MAXC];
    bit         s_full  [MAXC];
    bit         s_arm   [MAXC];

    int         cyc       = 0;
    int         fill      = 0;
    int         scn_start = 0;
    int         obs_idx [$];
    logic [7:0] obs_dat [$];
    int         exp_idx [$];
    logic [7:0] exp_dat [$];
    bit         m_trig, m_ovf, m_auto;
    int         m_phase;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] d, input bit v, input bit f, input bit a);
        s_data[fill]  = d;
        s_valid[fill] = v;
        s_full[fill]  = f;
        s_arm[fill]   = a;
        fill++;
    endtask

    // Apply queued stimulus, one entry per clock; a write seen after the edge
    // of stimulus cycle c is high during cycle c+1.
    task automatic play();
        while (cyc < fill) begin
            adc_data  = s_data[cyc];
            adc_valid = s_valid[cyc];
            wr_full   = s_full[cyc];
            arm       = s_arm[cyc];
            @(posedge wr_clk);
            #1;
            if (wr_en) begin
                obs_idx.push_back(cyc + 1);
                obs_dat.push_back(wr_data);
            end
            cyc++;
        end
        adc_valid = 1'b0;
        wr_full   = 1'b0;
        arm       = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        logic [12:0] status;
        wr_rst    = 1'b1;
        arm       = 1'b0;
        adc_valid = 1'b0;
        wr_full   = 1'b0;
        @(posedge wr_clk);
        #1;
        status = {wr_en, busy, done, triggered, overflow, wr_data};
        check_value({tag, ".reset_state"}, 32'(status), 32'd0);
`ifdef TRIG_AUTO_EN
        check_value({tag, ".reset_auto"}, 32'(auto_trig), 32'd0);
`endif
        wr_rst = 1'b0;
        cyc++;
        fill      = cyc;
        scn_start = cyc;
        obs_idx.delete();
        obs_dat.delete();
    endtask

    // Reference: walk the recorded sample stream, keep every (decim+1)-th
    // valid sample after an arm, and derive the expected FIFO writes.
    // phase: 0 idle, 1 awaiting first sample, 2 waiting for trigger,
    // 3 capturing, 4 finished.
    task automatic model(input int from, input int to);
        int phase, vcnt, nwr, len_eff, prev, cur, lvl;
        bit acc, hit, auto_hit;
`ifdef TRIG_AUTO_EN
        int armed_at;
        armed_at = 0;
`endif
        phase = 0; vcnt = 0; nwr = 0; prev = 0;
        m_trig = 0; m_ovf = 0; m_auto = 0;
        exp_idx.delete();
        exp_dat.delete();
        len_eff = (int'(capture_len) > (1 << DEP)) ? (1 << DEP) : int'(capture_len);
        lvl = int'(trig_level);
        for (int s = from; s < to; s++) begin
            if (s_arm[s] && (phase == 0 || phase == 4)) begin
                phase = 1; vcnt = 0; nwr = 0;
                m_trig = 0; m_ovf = 0; m_auto = 0;
                continue;
            end
            if (!s_valid[s] || phase == 0 || phase == 4) continue;
            acc = ((vcnt % (int'(decim) + 1)) == 0);
            vcnt++;
            if (!acc) continue;
            cur = int'(s_data[s]);
            if (phase == 1) begin
                prev  = cur;
                phase = 2;
`ifdef TRIG_AUTO_EN
                armed_at = s;
`endif
                continue;
            end
            if (phase == 2) begin
                hit = trig_edge ? (prev > lvl && cur <= lvl) : (prev < lvl && cur >= lvl);
                auto_hit = 1'b0;
`ifdef TRIG_AUTO_EN
                auto_hit = (s >= armed_at + 1 + AUTO);
`endif
                prev = cur;
                if (!hit && !auto_hit) continue;
                if (hit) m_trig = 1'b1;
                else     m_auto = 1'b1;
                if (len_eff == 0) begin
                    phase = 4;
                    continue;
                end
                phase = 3;
            end
            if (s_full[s]) begin
                m_ovf = 1'b1;
            end else begin
                exp_idx.push_back(s + 1);
                exp_dat.push_back(s_data[s]);
                nwr++;
                if (nwr == len_eff) phase = 4;
            end
        end
        m_phase = phase;
    endtask

    task automatic check_run(input string tag);
        int n;
        model(scn_start, cyc);
        check_value({tag, ".nwrites"}, 32'(obs_idx.size()), 32'(exp_idx.size()));
        n = (obs_idx.size() < exp_idx.size()) ? obs_idx.size() : exp_idx.size();
        for (int i = 0; i < n; i++) begin
            check_value($sformatf("%s.write%0d(cyc<<8|data)", tag, i),
                        32'((obs_idx[i] << 8) | int'(obs_dat[i])),
                        32'((exp_idx[i] << 8) | int'(exp_dat[i])));
        end
        check_value({tag, ".triggered"}, 32'(triggered), 32'(m_trig));
        check_value({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        check_value({tag, ".busy"},      32'(busy),      32'(m_phase >= 1 && m_phase <= 3));
        check_value({tag, ".done"},      32'(done),      32'(m_phase == 4));
`ifdef TRIG_AUTO_EN
        check_value({tag, ".auto_trig"}, 32'(auto_trig), 32'(m_auto));
`endif
    endtask

    task automatic setup(input int dcm, input int lvl, input bit edg, input int len);
        decim       = 16'(dcm);
        trig_level  = 8'(lvl);
        trig_edge   = edg;
        capture_len = (DEP + 1)'(len);
    endtask

    initial begin
        // Rising ramp, every sample kept
        do_reset("ramp");
        setup(0, 100, 1'b0, 8);
        put(8'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 140; i++) put(8'(i), 1'b1, 1'b0, 1'b0);
        play();
        check_run("ramp");
        if (obs_dat.size() > 0) check_value("ramp.first_data", 32'(obs_dat[0]), 32'd100);

        // Ramp with 1-in-4 decimation
        do_reset("decim3");
        setup(3, 100, 1'b0, 8);
        put(8'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 200; i++) put(8'(i), 1'b1, 1'b0, 1'b0);
        play();
        check_run("decim3");
        if (obs_dat.size() > 1) check_value("decim3.step", 32'(obs_dat[1] - obs_dat[0]), 32'd4);

        // Falling edge; flat samples at the level and a stray arm do nothing
        do_reset("falling");
        setup(0, 100, 1'b1, 3);
        put(8'd0, 1'b0, 1'b0, 1'b1);
        put(8'd100, 1'b1, 1'b0, 1'b0);
        put(8'd100, 1'b1, 1'b0, 1'b0);
        put(8'd100, 1'b1, 1'b0, 1'b1);
        put(8'd100, 1'b1, 1'b0, 1'b0);
        put(8'd200, 1'b1, 1'b0, 1'b0);
        put(8'd150, 1'b1, 1'b0, 1'b0);
        put(8'd90,  1'b1, 1'b0, 1'b0);
        put(8'd80,  1'b1, 1'b0, 1'b0);
        put(8'd70,  1'b1, 1'b0, 1'b0);
        put(8'd60,  1'b1, 1'b0, 1'b0);
        put(8'd50,  1'b0, 1'b0, 1'b0);
        play();
        check_run("falling");
        if (obs_dat.size() > 0) check_value("falling.first_data", 32'(obs_dat[0]), 32'd90);

        // FIFO full on the 3rd and 4th write attempts
        do_reset("full");
        setup(0, 100, 1'b0, 6);
        put(8'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 140; i++) put(8'(i), 1'b1, (i == 102 || i == 103), 1'b0);
        play();
        check_run("full");

        // Length above FIFO depth saturates to 2^DEP
        do_reset("sat");
        setup(0, 100, 1'b0, 31);
        put(8'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 160; i++) put(8'(i), 1'b1, 1'b0, 1'b0);
        play();
        check_run("sat");
        check_value("sat.count", 32'(obs_idx.size()), 32'(1 << DEP));

        // Zero length: trigger goes straight to done
        do_reset("len0");
        setup(0, 100, 1'b0, 0);
        put(8'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 120; i++) put(8'(i), 1'b1, 1'b0, 1'b0);
        play();
        check_run("len0");

        // Reset in the middle of a capture, then a clean restart
        do_reset("midcap");
        setup(0, 100, 1'b0, 8);
        put(8'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i <= 104; i++) put(8'(i), 1'b1, 1'b0, 1'b0);
        play();
        check_run("midcap_pre");
        do_reset("midcap_rst");
        put(8'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 130; i++) put(8'(i + 50), 1'b1, 1'b0, 1'b0);
        play();
        check_run("midcap_post");

        // Randomized streams, including re-arms and back-pressure
        for (int r = 0; r < 6; r++) begin
            do_reset($sformatf("rand%0d", r));
            setup($urandom_range(0, 3), $urandom_range(40, 215), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 31));
            put(8'd0, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 400; i++) begin
                put(8'($urandom_range(0, 255)),
                    ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 19) < 3),
                    ($urandom_range(0, 49) == 0));
            end
            play();
            check_run($sformatf("rand%0d", r));
        end

`ifdef TRIG_AUTO_EN
        // Constant input below the level never crosses; timeout fires
        do_reset("auto");
        setup(0, 100, 1'b0, 5);
        put(8'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 120; i++) put(8'd10, 1'b1, 1'b0, 1'b0);
        play();
        check_run("auto");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
